// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues single-outstanding word
// requests to instruction memory and buffers {pc, instr} pairs for decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FLUSH
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_e            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       req_pc_q, req_pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    entry_t            mem_q [FIFO_DEPTH];
    entry_t            head;

    logic              push;
    logic              pop;
    logic [31:0]       redirect_tgt;
    logic              unused_redirect_lsbs;

    assign redirect_tgt         = {redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // A response is only kept when it answers a live request; FLUSH and redirect drop it.
    assign push = (state_q == WAIT) && imem_rvalid_i && !redirect_i;
    assign pop  = instr_valid_o && instr_ready_i && !redirect_i;

    // ------------------------------------------------------------------
    // Instruction buffer bookkeeping
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        imem_req_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (redirect_i || (count_q < DEPTH_C)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                imem_req_o = 1'b1;
                if (imem_gnt_i) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    req_pc_d   = fetch_pc_q;
                    state_d    = redirect_i ? FLUSH : WAIT;
                end
            end
            WAIT: begin
                // count_d already reflects this cycle's push, pop or redirect clear.
                if (imem_rvalid_i) begin
                    state_d = (count_d < DEPTH_C) ? REQ : IDLE;
                end else if (redirect_i) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (imem_rvalid_i) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (redirect_i) begin
            fetch_pc_d = redirect_tgt;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // NOTE: buffer storage is not reset; count_q alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{pc: req_pc_q, instr: imem_rdata_i};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign head          = mem_q[rd_ptr_q];
    assign imem_addr_o   = fetch_pc_q;
    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_valid_o ? head.instr : 32'h0;
    assign instr_pc_o    = instr_valid_o ? head.pc    : 32'h0;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage that feeds the decode/control stage.
- Owns the fetch PC and issues word requests to instruction memory over a request/grant/rvalid handshake.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- Accepts PC redirects (jumps, branches) from downstream and flushes stale instructions.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
imem_req_o  output  1  fetch request valid
imem_addr_o  output  32  fetch byte address, word aligned
imem_gnt_i  input  1  memory accepts request this cycle
imem_rvalid_i  input  1  read data valid, in order, >=1 cycle after gnt
imem_rdata_i  input  32  instruction word
instr_valid_o  output  1  FIFO head valid to decode
instr_o  output  32  FIFO head instruction (feeds opcode/funct3/funct7 decode)
instr_pc_o  output  32  PC of instr_o
instr_ready_i  input  1  decode consumes head this cycle
redirect_i  input  1  downstream redirect strobe
redirect_pc_i  input  32  redirect target; bits[1:0] forced to 0

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, state=IDLE, FIFO count=0, imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0. Reset mid-transaction abandons any outstanding request; a late rvalid after release is ignored (state IDLE).
- imem_addr_o = fetch_pc (registered). fetch_pc advances by 4 on each accepted grant and wraps modulo 2^32.
- At most one outstanding request.
- FSM:
  - IDLE: imem_req_o=0. Go to REQ when count<FIFO_DEPTH, using the registered count.
  - REQ: imem_req_o=1, address held stable until gnt (except on redirect). On gnt: fetch_pc+=4, latch req_pc=fetch_pc, go to WAIT.
  - WAIT: imem_req_o=0. On rvalid: push {req_pc, rdata}, then go to REQ if count after this cycle's push/pop < FIFO_DEPTH, else IDLE.
  - FLUSH: imem_req_o=0. Waits for the stale rvalid, discards it, then goes to REQ.
- Throughput: 1 instruction per 2 cycles with single-cycle memory. Latency: gnt at cycle N, rvalid at N+1, instr_valid_o at N+2 (FIFO output registered, no bypass).
- FIFO: push on accepted rvalid, pop when instr_valid_o && instr_ready_i. Simultaneous push and pop when full or empty is legal; count is unchanged when full. Push is never lost: space is reserved before the request is issued. instr_ready_i while empty is ignored.
- Redirect (highest priority):
  - FIFO cleared, so instr_valid_o=0 next cycle; any pop in that cycle is discarded.
  - fetch_pc <= {redirect_pc_i[31:2],2'b00}.
  - In REQ without gnt: next state REQ with the new address (address change without gnt is permitted only here).
  - In REQ with gnt same cycle, or in WAIT without rvalid: go to FLUSH.
  - In WAIT with rvalid same cycle: response discarded, go to REQ.
  - In FLUSH: update fetch_pc; stay in FLUSH until rvalid.
  - In IDLE: go to REQ.
- imem_rvalid_i in IDLE or REQ is a protocol error and is ignored. imem_gnt_i while imem_req_o=0 is ignored.

Test Plan:
- Reset release with gnt tied 1 and 1-cycle rvalid returning 32'h0000_0013 -> imem_addr_o sequence 0x0,0x4,0x8; instr_pc_o 0x0 valid 3 cycles after release; pairs arrive in order.
- instr_ready_i=0 while fetching -> 2 instructions buffered, imem_req_o held low, no 3rd request. Ready reasserted -> head pops, new request at the next sequential PC.
- Redirect to 0x0000_1002 in WAIT before rvalid -> FLUSH; stale rdata not presented; next imem_addr_o=0x0000_1000; instr_pc_o=0x1000 next.
- Redirect in the same cycle as rvalid and as instr_ready_i with FIFO holding 1 entry -> instr_valid_o=0 next cycle, both entries discarded, REQ at target.
- gnt withheld 5 cycles -> imem_req_o and imem_addr_o stable throughout. fetch_pc=0xFFFF_FFFC accepted -> next address 0x0000_0000.
- rst_n_i asserted while in WAIT -> outputs at reset values immediately (async). rvalid pulse after release ignored; fetch restarts at RESET_PC.
